// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids, access sizes.
// Pure declarations, no logic.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_R = 2'd2,
        BUSY_W = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_I    = 2'd1,
        SRC_R    = 2'd2,
        SRC_W    = 2'd3
    } req_src_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic arb_state_e busy_state(input req_src_e src);
        arb_state_e s;
        case (src)
            SRC_I:   s = BUSY_I;
            SRC_R:   s = BUSY_R;
            SRC_W:   s = BUSY_W;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    function automatic req_src_e state_src(input arb_state_e st);
        req_src_e s;
        case (st)
            BUSY_I:  s = SRC_I;
            BUSY_R:  s = SRC_R;
            BUSY_W:  s = SRC_W;
            default: s = SRC_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Grant selection: store > load > fetch, unless fetch has waited long enough to be forced.
// Combinational, zero latency; requesters are never stalled here, only ranked.
module arb_prio_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic     i_req,
    input  logic     r_req,
    input  logic     w_req,
    input  logic     force_fetch,
    output req_src_e grant
);

    always_comb begin
        grant = SRC_NONE;
        if (i_req && force_fetch) begin
            grant = SRC_I;
        end else if (w_req) begin
            grant = SRC_W;
        end else if (r_req) begin
            grant = SRC_R;
        end else if (i_req) begin
            grant = SRC_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch/load/store onto one memory port, bounds fetch starvation, aborts hung accesses.
// Grant-to-mem_req latency 1 cycle; acks are the same-cycle mem_ack; requesters hold req until ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_SKIP = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_ack,
    output logic [DATA_W-1:0] r_rdata,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [1:0]        w_size,
    output logic              w_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [1:0]        err_src
);

    localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
    localparam int TO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);

    arb_state_e        state_q,     state_d;
    logic [SKIP_W-1:0] skip_cnt_q,  skip_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_size_q,  mem_size_d;
    logic              err_q,       err_d;
    req_src_e          err_src_q,   err_src_d;

    req_src_e grant;

    arb_prio_sel u_prio_sel (
        .i_req       (i_req),
        .r_req       (r_req),
        .w_req       (w_req),
        .force_fetch (skip_cnt_q == SKIP_MAX),
        .grant       (grant)
    );

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        to_cnt_d    = to_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        err_d       = 1'b0;
        err_src_d   = SRC_NONE;

        if (state_q == IDLE) begin
            if (grant != SRC_NONE) begin
                state_d   = busy_state(grant);
                mem_req_d = 1'b1;
                to_cnt_d  = '0;
                // Count only data grants that actually made a waiting fetch wait.
                if (!i_req || grant == SRC_I) begin
                    skip_cnt_d = '0;
                end else if (skip_cnt_q != SKIP_MAX) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                end
                case (grant)
                    SRC_W: begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = w_addr;
                        mem_wdata_d = w_data;
                        mem_size_d  = w_size;
                    end
                    SRC_R: begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = r_addr;
                        mem_size_d = SZ_WORD;
                    end
                    default: begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                        mem_size_d = SZ_WORD;
                    end
                endcase
            end
        end else begin
            // A late ack on the timeout cycle still wins over the abort.
            if (mem_ack) begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                to_cnt_d  = '0;
            end else if (to_cnt_q == TO_MAX) begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                to_cnt_d  = '0;
                err_d     = 1'b1;
                err_src_d = state_src(state_q);
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            skip_cnt_q  <= '0;
            to_cnt_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= SZ_WORD;
            err_q       <= 1'b0;
            err_src_q   <= SRC_NONE;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            err_q       <= err_d;
            err_src_q   <= err_src_d;
        end
    end

    assign i_ack     = (state_q == BUSY_I) && mem_ack;
    assign r_ack     = (state_q == BUSY_R) && mem_ack;
    assign w_ack     = (state_q == BUSY_W) && mem_ack;
    assign i_rdata   = mem_rdata;
    assign r_rdata   = mem_rdata;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign err       = err_q;
    assign err_src   = err_src_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between three requesters: instruction fetch, data load (read) and data store (write).
- Sits between the fetch/execute stages and the memory interface.
- Serialises one transaction at a time, prioritises data traffic and bounds fetch starvation.
- Aborts transactions that memory never acknowledges, flagging an error.

Parameters:
ADDR_W, 32, address width for all requesters and the memory port
DATA_W, 32, data width
MAX_SKIP, 3, consecutive data grants allowed while a fetch waits before fetch is forced
TIMEOUT, 15, cycles in a BUSY state without mem_ack before abort

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, level; held until i_ack
i_addr  in  ADDR_W  fetch address
i_ack  out  1  fetch complete, one-cycle pulse
i_rdata  out  DATA_W  fetched instruction, valid when i_ack
r_req  in  1  load request, level
r_addr  in  ADDR_W  load address
r_ack  out  1  load complete pulse
r_rdata  out  DATA_W  load data, valid when r_ack
w_req  in  1  store request, level
w_addr  in  ADDR_W  store address
w_data  in  DATA_W  store data
w_size  in  2  store size: 00 byte, 01 half, 10 word
w_ack  out  1  store complete pulse
mem_req  out  1  memory transaction active
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_size  out  2  access size; 10 for all reads
mem_ack  in  1  memory completion, one-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack
err  out  1  timeout pulse
err_src  out  2  source of the aborted transaction: 01 fetch, 10 load, 11 store; 00 otherwise

Behaviour:
- Reset values (asynchronous, while reset=1): state IDLE; mem_req, mem_we, mem_addr, mem_wdata all 0; mem_size=10; skip_cnt=0; to_cnt=0; err=0; err_src=00.
- The *_ack outputs are combinational from registered state, so they are also 0 during reset.
- States: IDLE, BUSY_I, BUSY_R, BUSY_W.
- IDLE grant selection, evaluated each cycle:
  - If i_req=1 and skip_cnt==MAX_SKIP, grant fetch.
  - Otherwise priority is w_req > r_req > i_req.
  - No request: stay in IDLE.
- Grant:
  - Next edge: enter the BUSY state and register addr/wdata/size/we from the winning requester.
  - mem_req=1 from the first BUSY cycle; 1-cycle minimum arbitration latency.
  - Memory outputs stay stable for the whole BUSY period.
- skip_cnt:
  - On a data grant with i_req=1: increment, saturating at MAX_SKIP.
  - On a fetch grant: clear.
  - On any grant with i_req=0: clear.
- BUSY_x with mem_ack=1:
  - Matching x_ack=1 in the same cycle; x_rdata = mem_rdata, passthrough.
  - Next edge: IDLE, mem_req=0, to_cnt=0.
- Non-selected acks are always 0, so at most one ack is asserted per cycle.
- Requesters drop req on the edge where they sample ack. The arbiter re-evaluates only in IDLE, so no duplicate grant occurs.
- BUSY without mem_ack: to_cnt increments each cycle.
- Timeout abort, when to_cnt==TIMEOUT and mem_ack=0:
  - Next edge: IDLE, mem_req=0.
  - err=1 for one cycle, with err_src set to the aborted source.
  - No ack is issued to the requester. It keeps req high and is re-arbitrated normally.
- mem_ack arriving in the same cycle as to_cnt==TIMEOUT counts as success: no err.
- mem_ack while IDLE is ignored.
- i_rdata/r_rdata are don't-care when not acked. The bench compares them only on ack.
- reset asserted mid-transaction: immediate return to IDLE; the pending transaction is dropped without ack.
- Request inputs are not required to be stable in IDLE. Only values sampled at the grant edge matter.

Decomposition:
- Shared package (my_pkg):
  - typedef enum arb_state {IDLE, BUSY_I, BUSY_R, BUSY_W}.
  - typedef enum req_src {SRC_NONE=0, SRC_I=1, SRC_R=2, SRC_W=3}, used for err_src.
  - Size constants SZ_BYTE, SZ_HALF, SZ_WORD.
- One sub-module is natural: arb_prio_sel.
  - Combinational grant selection from w_req, r_req, i_req and the force_fetch flag.
  - Outputs a req_src.
- State, counters and output registers live in mem_port_arbiter.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; memory acks 2 cycles after mem_req with 0x00000013. Required: mem_req high 1 cycle after i_req, mem_addr=0x100, mem_we=0; i_ack=1 with i_rdata=0x00000013 in the mem_ack cycle; IDLE next cycle.
- Simultaneous requests: i_req, r_req and w_req all asserted in the same cycle (w_addr=0x200, w_data=0xDEADBEEF, w_size=10). Required grant order: store, then load, then fetch; mem_we=1 only for the first transaction; exactly one ack per transaction.
- Starvation bound: i_req held while w_req/r_req are re-asserted continuously. Required: the fetch is granted after exactly MAX_SKIP=3 data grants, then skip_cnt=0.
- Timeout: r_req=1, memory never acks. Required: err=1 for one cycle, err_src=10, exactly TIMEOUT+1 cycles after mem_req rose; no r_ack; load re-granted next IDLE cycle.
- Boundary ack: mem_ack coincides with to_cnt==TIMEOUT. Required: w_ack=1, err stays 0.
- Reset mid-BUSY_W: reset pulse while mem_req=1. Required: mem_req=0 asynchronously, no w_ack, skip_cnt=0; a fresh request after reset is granted normally.
